// File: rtl/dh_cal.sv
// Streaming squared-column-norm calculator: sums (re^2 + im^2) >> Q over
// batches of 8 accepted samples and emits a saturated Q-format result per batch.
module dh_cal #(
    parameter int Q = 8,
    parameter int N = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Dh_en,
    input  logic signed [N-1:0] in_real,
    input  logic signed [N-1:0] in_im,
    output logic signed [N-1:0] Dh_out,
    output logic                Dh_result_valid
);

    localparam int PW = 2 * N + 1;
    localparam int AW = 2 * N + 4;
    localparam logic [AW-1:0] SAT_MAX = {{(N + 5){1'b0}}, {(N - 1){1'b1}}};

    logic signed [2*N-1:0] re_sq;
    logic signed [2*N-1:0] im_sq;
    logic [PW-1:0]         power;
    logic [PW-1:0]         term;
    logic [AW-1:0]         sum;
    logic [N-1:0]          sum_sat;

    logic [AW-1:0] acc_q, acc_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [N-1:0]  dh_q, dh_d;
    logic          valid_q, valid_d;

    // Squares of signed values are non-negative, so zero-extension is exact.
    assign re_sq = in_real * in_real;
    assign im_sq = in_im * in_im;
    assign power = {1'b0, re_sq} + {1'b0, im_sq};
    assign term  = power >> Q;
    assign sum   = acc_q + {3'b000, term};
    assign sum_sat = (sum > SAT_MAX) ? SAT_MAX[N-1:0] : sum[N-1:0];

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dh_d    = dh_q;
        valid_d = 1'b0;
        if (Dh_en) begin
            if (cnt_q == 3'd7) begin
                // Last sample of the batch: publish and restart cleanly.
                dh_d    = sum_sat;
                valid_d = 1'b1;
                acc_d   = '0;
                cnt_d   = 3'd0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q   <= '0;
            cnt_q   <= 3'd0;
            dh_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dh_q    <= dh_d;
            valid_q <= valid_d;
        end
    end

    assign Dh_out          = dh_q;
    assign Dh_result_valid = valid_q;

endmodule

// File: tb/tb_dh_cal.sv
// Directed self-checking bench for dh_cal with hand-computed batch results.
module tb_dh_cal;

    logic               clk;
    logic               rst;
    logic               Dh_en;
    logic signed [15:0] in_real;
    logic signed [15:0] in_im;
    logic signed [15:0] Dh_out;
    logic               Dh_result_valid;

    int errors;
    int checks;
    int cyc;

    dh_cal #(.Q(8), .N(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .Dh_en           (Dh_en),
        .in_real         (in_real),
        .in_im           (in_im),
        .Dh_out          (Dh_out),
        .Dh_result_valid (Dh_result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Feeds a batch of 8 identical samples; gaps of 1..maxgap idle cycles when maxgap > 0.
    task automatic feed(input logic [15:0] re, input logic [15:0] im, input int maxgap,
                        input string name, output int pulse_cyc);
        int gap;
        pulse_cyc = -1;
        for (int i = 0; i < 8; i++) begin
            in_real = re;
            in_im   = im;
            Dh_en   = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (Dh_result_valid !== (i == 7)) begin
                errors++;
                $display("FAIL %s_valid sample %0d: got %b want %b", name, i, Dh_result_valid, (i == 7));
            end
            if (i == 7) pulse_cyc = cyc;
            if (maxgap > 0 && i < 7) begin
                Dh_en = 1'b0;
                gap = $urandom_range(1, maxgap);
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                    checks++;
                    if (Dh_result_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL %s_gap_valid sample %0d: got %b want 0", name, i, Dh_result_valid);
                    end
                end
            end
        end
        Dh_en = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [15:0] want);
        checks++;
        if (Dh_out !== want) begin
            errors++;
            $display("FAIL %s: Dh_out got %h want %h", name, Dh_out, want);
        end
    endtask

    task automatic idle_check(input string name, input logic [15:0] want);
        @(posedge clk); #1;
        checks++;
        if (Dh_result_valid !== 1'b0 || Dh_out !== want) begin
            errors++;
            $display("FAIL %s: valid=%b out=%h want valid=0 out=%h", name, Dh_result_valid, Dh_out, want);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; Dh_en = 1'b1; in_real = 16'h0100; in_im = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (Dh_out !== 16'h0000 || Dh_result_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out=%h valid=%b want 0000/0", Dh_out, Dh_result_valid);
        end
        Dh_en = 1'b0;
        rst = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_basic;
        int p;
        feed(16'h0100, 16'h0000, 0, "basic", p);
        expect_out("basic_out", 16'h0800);
        idle_check("basic_hold", 16'h0800);
        $display("test_basic: out=%h", Dh_out);
    endtask

    task automatic test_back_to_back;
        int p1, p2;
        feed(16'h0100, 16'h0100, 0, "b2b_a", p1);
        expect_out("b2b_a_out", 16'h1000);
        feed(16'hFF00, 16'h0080, 0, "b2b_b", p2);
        expect_out("b2b_b_out", 16'h0A00);
        checks++;
        if (p2 - p1 != 8) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles want 8", p2 - p1);
        end
        idle_check("b2b_hold", 16'h0A00);
        $display("test_back_to_back: spacing=%0d out=%h", p2 - p1, Dh_out);
    endtask

    task automatic test_saturation;
        int p;
        feed(16'h7FFF, 16'h7FFF, 0, "sat", p);
        expect_out("sat_out", 16'h7FFF);
        feed(16'h0000, 16'h0000, 0, "zero", p);
        expect_out("zero_out", 16'h0000);
        $display("test_saturation: out=%h", Dh_out);
    endtask

    task automatic test_truncation;
        int p;
        feed(16'h0001, 16'h0001, 0, "trunc", p);
        expect_out("trunc_out", 16'h0000);
        $display("test_truncation: out=%h", Dh_out);
    endtask

    task automatic test_gaps;
        int p;
        feed(16'h0100, 16'h0000, 3, "gaps", p);
        expect_out("gaps_out", 16'h0800);
        $display("test_gaps: out=%h", Dh_out);
    endtask

    task automatic test_reset_midbatch;
        int p;
        in_real = 16'h0100; in_im = 16'h0000; Dh_en = 1'b1;
        repeat (3) @(posedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (Dh_out !== 16'h0000 || Dh_result_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_during cycle %0d: out=%h valid=%b want 0000/0", i, Dh_out, Dh_result_valid);
            end
        end
        rst = 1'b1; Dh_en = 1'b0;
        feed(16'h0100, 16'h0000, 0, "midrst", p);
        expect_out("midrst_out", 16'h0800);
        $display("test_reset_midbatch: out=%h", Dh_out);
    endtask

    task automatic test_reset_on_last;
        int p;
        in_real = 16'h0100; in_im = 16'h0100; Dh_en = 1'b1;
        repeat (7) @(posedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (Dh_result_valid !== 1'b0 || Dh_out !== 16'h0000) begin
            errors++;
            $display("FAIL rst_on_last: valid=%b out=%h want 0/0000", Dh_result_valid, Dh_out);
        end
        rst = 1'b1; Dh_en = 1'b0;
        feed(16'hFF00, 16'h0080, 0, "after_rst", p);
        expect_out("after_rst_out", 16'h0A00);
        $display("test_reset_on_last: out=%h", Dh_out);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0; Dh_en = 1'b0; in_real = '0; in_im = '0;
        test_reset;
        test_basic;
        test_back_to_back;
        test_saturation;
        test_truncation;
        test_gaps;
        test_reset_midbatch;
        test_reset_on_last;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dh_cal.md
# dh_cal

Streaming diagonal-metric calculator for the MIMO detector front end. It accepts complex channel samples in signed Q8.8 fixed point, one per enabled cycle. For each group of 8 accepted samples (two 4-row columns of the channel matrix Hq), it produces Dh = Σ(re² + im²), the squared column norm used as the diagonal term of the detector. It sits between the Hq buffer and the detection datapath; one result is produced per 8-sample batch.

## Interface
- `Q`, default 8: number of fractional bits of input and output.
- `N`, default 16: total word width of input and output (signed two's complement).
- `clk`, input, 1: single clock; all state updates on rising edge.
- `rst`, input, 1: reset, synchronous, active-low; sampled on the `clk` rising edge.
- `Dh_en`, input, 1: sample-valid strobe; `in_real`/`in_im` are consumed on every rising edge where it is 1.
- `in_real`, input, N (signed): real part of the Hq sample.
- `in_im`, input, N (signed): imaginary part of the Hq sample.
- `Dh_out`, output, N (signed): Dh result in Q8.8, always ≥ 0.
- `Dh_result_valid`, output, 1: one-cycle pulse marking a new `Dh_out`.

## Operation
- Per accepted sample:
  - p = in_real² + in_im², computed exactly in an unsigned 2N+1-bit value.
  - Then shifted right by Q (truncation, no rounding), giving term t.
- Accumulator:
  - Unsigned, 2N+4 bits wide; cannot overflow for 8 terms.
  - Adds t on each accepted sample.
- Sample counter:
  - 3 bits, counts accepted samples 0..7.
  - Advances only when `Dh_en`=1; cycles with `Dh_en`=0 are ignored and gaps are allowed anywhere in a batch.
- Batch completion, when the 8th sample of a batch is accepted:
  - The final sum (accumulator + t) is saturated to 2^(N-1)−1 (0x7FFF) if larger, and registered into `Dh_out`.
  - `Dh_result_valid` is set.
  - Accumulator and counter clear to 0 on the same edge, so the next batch starts cleanly and may begin on the very next cycle.
- States, implicit in the counter: IDLE/ACCUM (count 0..7) → RESULT (valid pulse) → back to ACCUM. There is no explicit start signal; the first accepted sample after reset or after a completed batch is sample 0.
- `Dh_out` holds its last result until the next batch completes.
- Reset (`rst`=0 at a rising edge):
  - Accumulator, counter, `Dh_out` and `Dh_result_valid` all go to 0.
  - A partially accumulated batch is discarded.
  - `Dh_en` is ignored while reset is active.

## Timing
- Latency: `Dh_out` and `Dh_result_valid` update on the same rising edge that accepts the 8th sample. Both are registered, so they become visible in the cycle after that edge.
- `Dh_result_valid` is high for exactly one cycle per batch, then returns to 0 unless another batch completes on the next edge.
- Maximum throughput is one sample per cycle, i.e. one result every 8 cycles.
- Inputs have no setup requirement beyond standard synchronous capture; no backpressure.
- Reset values: `Dh_out`=0x0000, `Dh_result_valid`=0.
- Reset asserted on the same edge as the 8th sample: reset wins, and no valid pulse is produced.

## Test plan
- Reset, then 8 consecutive samples re=0x0100, im=0x0000 → one valid pulse the cycle after the 8th edge, `Dh_out`=0x0800 (8.0).
- 8 samples re=0x0100, im=0x0100, immediately followed by 8 samples re=0xFF00 (−1.0), im=0x0080 → first result 0x1000 (16.0); second result 0x0A00 (10.0), with the second pulse exactly 8 cycles after the first.
- 8 samples re=0x7FFF, im=0x7FFF → `Dh_out` saturates to 0x7FFF; next batch of zeros → 0x0000.
- 8 samples re=0x0001, im=0x0001 (each term truncates to 0) → `Dh_out`=0x0000, valid still pulses.
- Same stimulus as the first scenario, with `Dh_en` low for 1–3 random cycles between samples → `Dh_out`=0x0800, pulse only after the 8th enabled sample, no pulse earlier.
- Feed 3 samples of 0x0100/0x0000, assert `rst`=0 for 2 cycles, then feed 8 samples of 0x0100/0x0000 → outputs read 0 during reset; a single result of 0x0800 appears after the 8th post-reset sample.
